// File: rtl/frame_sequencer.sv
// Frame capture controller for the pixel array: erase, exposure, ramp conversion,
// then a stallable row/beat readout. All outputs are registered Moore decodes of the next state.
module frame_sequencer #(
    parameter int WIDTH                  = 4,
    parameter int HEIGHT                 = 2,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
    parameter int BIT_DEPTH              = 10,
    parameter int ERASE_CYCLES           = 5,
    parameter int EXPOSE_W               = 8,
    localparam int BEATS  = WIDTH / OUTPUT_BUS_PIXEL_WIDTH,
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                SYSTEM_CLK,
    input  logic                SYSTEM_RESET_N,
    input  logic                START,
    input  logic                ABORT,
    input  logic [EXPOSE_W-1:0] CFG_EXPOSE,
    input  logic                CFG_CONTINUOUS,
    input  logic                DATA_READY,
    output logic                BUSY,
    output logic                FRAME_DONE,
    output logic [7:0]          FRAME_COUNT,
    output logic                POWER_ENABLE,
    output logic                WRITE_ENABLE,
    output logic                COUNTER_RESET,
    output logic                ERASE,
    output logic                EXPOSE,
    output logic                CONVERT,
    output logic [BIT_DEPTH-1:0] RAMP_CODE,
    output logic                DATA_VALID,
    output logic [ROW_W-1:0]    READ_ROW,
    output logic [BEAT_W-1:0]   READ_BEAT
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int CNT_W = $clog2(max3(ERASE_CYCLES, 2**EXPOSE_W, 2**BIT_DEPTH) + 1);
    localparam logic [CNT_W-1:0]  ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CONV_LAST  = CNT_W'(2**BIT_DEPTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(HEIGHT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_DONE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_exp_last;
    logic [ROW_W-1:0]     r_row, w_row_nxt;
    logic [BEAT_W-1:0]    r_beat, w_beat_nxt;
    logic [EXPOSE_W-1:0]  r_exp_len, w_cfg_e;
    logic                 w_latch;
    logic                 r_busy, r_frame_done, r_power, r_write, r_erase, r_expose, r_convert, r_valid;
    logic [7:0]           r_frame_count;
    logic [BIT_DEPTH-1:0] r_ramp;

    // A zero exposure request is promoted to one cycle so EXPOSE always appears
    assign w_cfg_e    = (CFG_EXPOSE == '0) ? EXPOSE_W'(1) : CFG_EXPOSE;
    assign w_exp_last = CNT_W'(r_exp_len) - CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_row_nxt   = r_row;
        w_beat_nxt  = r_beat;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START && !ABORT) begin
                    w_state_nxt = S_ERASE;
                    w_latch     = 1'b1;
                end
            end
            S_ERASE:   if (r_cnt == ERASE_LAST) w_state_nxt = S_EXPOSE;
            S_EXPOSE:  if (r_cnt == w_exp_last) w_state_nxt = S_CONVERT;
            S_CONVERT: if (r_cnt == CONV_LAST)  w_state_nxt = S_READ;
            S_READ: begin
                if (DATA_READY) begin
                    if (r_beat == BEAT_LAST) begin
                        w_beat_nxt = '0;
                        if (r_row == ROW_LAST) w_state_nxt = S_DONE;
                        else                   w_row_nxt   = r_row + ROW_W'(1);
                    end else begin
                        w_beat_nxt = r_beat + BEAT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (CFG_CONTINUOUS) begin
                    w_state_nxt = S_ERASE;
                    w_latch     = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Abort overrides everything, including a continuous restart out of DONE
        if (ABORT && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_latch     = 1'b0;
        end
        if ((w_state_nxt != r_state) || (w_state_nxt inside {S_IDLE, S_READ, S_DONE})) w_cnt_nxt = '0;
        if (w_state_nxt != S_READ) begin
            w_row_nxt  = '0;
            w_beat_nxt = '0;
        end
    end

    always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_row         <= '0;
            r_beat        <= '0;
            r_exp_len     <= EXPOSE_W'(1);
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 8'd0;
            r_power       <= 1'b0;
            r_write       <= 1'b0;
            r_erase       <= 1'b0;
            r_expose      <= 1'b0;
            r_convert     <= 1'b0;
            r_valid       <= 1'b0;
            r_ramp        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_row        <= w_row_nxt;
            r_beat       <= w_beat_nxt;
            if (w_latch) r_exp_len <= w_cfg_e;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_done <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) r_frame_count <= r_frame_count + 8'd1;
            r_power      <= (w_state_nxt inside {S_EXPOSE, S_CONVERT, S_READ});
            r_write      <= (w_state_nxt inside {S_EXPOSE, S_CONVERT});
            r_erase      <= (w_state_nxt == S_ERASE);
            r_expose     <= (w_state_nxt == S_EXPOSE);
            r_convert    <= (w_state_nxt == S_CONVERT);
            r_valid      <= (w_state_nxt == S_READ);
            r_ramp       <= (w_state_nxt == S_CONVERT) ? w_cnt_nxt[BIT_DEPTH-1:0] : '0;
        end
    end

    assign BUSY          = r_busy;
    assign FRAME_DONE    = r_frame_done;
    assign FRAME_COUNT   = r_frame_count;
    assign POWER_ENABLE  = r_power;
    assign WRITE_ENABLE  = r_write;
    assign COUNTER_RESET = r_erase;
    assign ERASE         = r_erase;
    assign EXPOSE        = r_expose;
    assign CONVERT       = r_convert;
    assign RAMP_CODE     = r_ramp;
    assign DATA_VALID    = r_valid;
    assign READ_ROW      = r_row;
    assign READ_BEAT     = r_beat;

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame-level controller for the digital pixel sensor array. It runs one complete capture per request: erase, programmable exposure, ramp conversion, then a row/beat readout that a downstream consumer can stall with a valid/ready handshake. The block drives the array's control strobes and a digital ramp code, and sits between the system controller (start/abort/configuration) and the pixel array plus its readout bus.

## Interface
- `WIDTH`, 4: pixels per row.
- `HEIGHT`, 2: rows.
- `OUTPUT_BUS_PIXEL_WIDTH`, 2: pixels per bus beat. `WIDTH` must be a multiple of it. `BEATS = WIDTH/OUTPUT_BUS_PIXEL_WIDTH`.
- `BIT_DEPTH`, 10: ramp code width. Conversion lasts `2**BIT_DEPTH` cycles.
- `ERASE_CYCLES`, 5: erase duration in cycles, minimum 1.
- `EXPOSE_W`, 8: width of the exposure configuration field.
- `SYSTEM_CLK` in 1: the single clock. All state changes on the rising edge.
- `SYSTEM_RESET_N` in 1: asynchronous, active-low reset.
- `START` in 1: frame request, sampled in IDLE only.
- `ABORT` in 1: cancels the frame in progress. Has priority over `START`.
- `CFG_EXPOSE` in `EXPOSE_W`: exposure length in cycles, latched when `START` is accepted.
- `CFG_CONTINUOUS` in 1: when 1, DONE goes straight to ERASE. Sampled in DONE.
- `DATA_READY` in 1: downstream accepts the current beat.
- `BUSY` out 1: state is not IDLE.
- `FRAME_DONE` out 1: one-cycle pulse in DONE.
- `FRAME_COUNT` out 8: completed frames. Wraps 255→0.
- `POWER_ENABLE`, `WRITE_ENABLE`, `COUNTER_RESET`, `ERASE`, `EXPOSE`, `CONVERT` out 1 each: array strobes.
- `RAMP_CODE` out `BIT_DEPTH`: digital ramp value during CONVERT, 0 otherwise.
- `DATA_VALID` out 1: the beat at `READ_ROW`/`READ_BEAT` is on the bus.
- `READ_ROW` out `max(1,$clog2(HEIGHT))`, `READ_BEAT` out `max(1,$clog2(BEATS))`: readout address.

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, READ, DONE. One cycle counter, wide enough for `max(ERASE_CYCLES, 2**EXPOSE_W, 2**BIT_DEPTH)`. The counter clears on every state entry.
- IDLE:
  - `START`=1 and `ABORT`=0 → ERASE.
  - Latch `E = max(CFG_EXPOSE, 1)`.
- ERASE:
  - `ERASE`=1 and `COUNTER_RESET`=1 for `ERASE_CYCLES` cycles.
  - Then → EXPOSE.
- EXPOSE:
  - `EXPOSE`, `POWER_ENABLE` and `WRITE_ENABLE` = 1 for E cycles.
  - Then → CONVERT.
- CONVERT:
  - `CONVERT`, `POWER_ENABLE` and `WRITE_ENABLE` = 1 for `2**BIT_DEPTH` cycles.
  - `RAMP_CODE` = 0,1,…,`2**BIT_DEPTH-1`, one step per cycle.
  - Then → READ.
- READ:
  - `POWER_ENABLE`=1 and `DATA_VALID`=1 throughout. Address starts at row 0, beat 0.
  - Each cycle with `DATA_VALID`&`DATA_READY`: beat+1. At beat `BEATS-1`, beat wraps to 0 and row+1.
  - Acceptance of row `HEIGHT-1`, beat `BEATS-1` → DONE.
  - `DATA_READY`=0 holds the address and `DATA_VALID` indefinitely; there is no timeout.
- DONE, one cycle:
  - `FRAME_DONE`=1 and `FRAME_COUNT`+1.
  - Next state is ERASE if `CFG_CONTINUOUS`=1, else IDLE. In the ERASE case, E is re-latched from `CFG_EXPOSE`.
- `ABORT`=1 in any non-IDLE state:
  - → IDLE on the next edge.
  - No `FRAME_DONE`, `FRAME_COUNT` unchanged, all strobes low from that edge.
  - `ABORT` in DONE suppresses the continuous restart but not that cycle's pulse/count, which are already registered.
- `START` while `BUSY` is ignored, not queued. `CFG_*` changes mid-frame have no effect.

## Timing
- All outputs are registered. Each is a pure function of the registered state and counter/address, valid in the same cycle the state is held (Moore).
- Reset (`SYSTEM_RESET_N`=0) is asynchronous:
  - state IDLE.
  - All outputs 0, including `FRAME_COUNT`, `RAMP_CODE`, `READ_ROW`, `READ_BEAT`.
  - Latched E = 1.
  - Reset mid-frame discards the frame silently.
- Latency:
  - `START` sampled at edge k → `BUSY`=`ERASE`=1 from edge k+1.
  - EXPOSE is entered at edge k+1+`ERASE_CYCLES`.
- With `DATA_READY` tied 1, the frame is `ERASE_CYCLES`+E+`2**BIT_DEPTH`+`HEIGHT*BEATS`+1 cycles from ERASE entry through DONE inclusive.
- Continuous mode: ERASE follows DONE with no IDLE cycle.

## Test plan
- Defaults, `CFG_EXPOSE`=255, `DATA_READY`=1, `START` pulse:
  - `ERASE` high 5 cycles, `EXPOSE` high 255, `CONVERT` high 1024 with `RAMP_CODE` 0→1023.
  - READ visits (0,0),(0,1),(1,0),(1,1).
  - `FRAME_DONE` pulses 1289 cycles after ERASE entry; `FRAME_COUNT`=1.
- `CFG_EXPOSE`=0 → `EXPOSE` high exactly 1 cycle.
- `DATA_READY` held 0 for 10 cycles at row 1, beat 0 → address and `DATA_VALID` stable for those cycles; the frame completes 2 accepted beats after `DATA_READY` rises.
- `ABORT` during CONVERT at `RAMP_CODE`=500 → IDLE next edge, all strobes 0, no `FRAME_DONE`, `FRAME_COUNT` unchanged. `START` and `ABORT` high together in IDLE → stays IDLE.
- `CFG_CONTINUOUS`=1, `FRAME_COUNT` preset to 255 by running 255 frames → ERASE directly after DONE; the 256th frame wraps the count to 0.
- `SYSTEM_RESET_N` asserted mid-EXPOSE between clock edges → all outputs 0 immediately. After release, `START` runs a clean frame from ERASE.
